// File: rtl/fifo_ctrl_6x8_pkg.sv
// Shared sizing for the lane FIFO controller: default pointer/data widths and depth helper.
package fifo_ctrl_6x8_pkg;

    localparam int MAIN_SIZE_DEF = 6;
    localparam int DATA_SIZE_DEF = 8;
    localparam int DEPTH_DEF     = 1 << MAIN_SIZE_DEF;
    localparam int THR_W_DEF     = MAIN_SIZE_DEF + 1;

    function automatic int depth_of(input int ptr_w);
        return 1 << ptr_w;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping address counter with enable; async active-low clear. Used for both FIFO pointers.
module fifo_ptr_cnt
    import fifo_ctrl_6x8_pkg::*;
#(
    parameter int W = MAIN_SIZE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    // Natural rollover at 2**W - 1 gives the circular addressing for free.
    always_comb begin
        q_next = q_reg;
        if (en) begin
            q_next = q_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fifo_ctrl_6x8.sv
// Synchronous FIFO controller for one memory6x8 instance: pointers, occupancy and status flags.
// Optional sticky overflow/underflow error register is built when FIFO_ERR_EN is defined.
module fifo_ctrl_6x8
    import fifo_ctrl_6x8_pkg::*;
#(
    parameter int MAIN_SIZE = MAIN_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [MAIN_SIZE:0]   af_thr,
    input  logic [MAIN_SIZE:0]   ae_thr,
    output logic                 write,
    output logic                 read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [MAIN_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 data_valid,
    output logic                 error
);

    localparam logic [MAIN_SIZE:0] DEPTH = {1'b1, {MAIN_SIZE{1'b0}}};
    localparam logic [MAIN_SIZE:0] ONE   = {{MAIN_SIZE{1'b0}}, 1'b1};

    // Data width only flows through to the memory; reject nonsensical sizing at elaboration.
    if (DATA_SIZE < 1 || MAIN_SIZE < 1) begin : g_bad_param
        $error("fifo_ctrl_6x8: DATA_SIZE and MAIN_SIZE must be positive");
    end

    logic                 push_ok;
    logic                 pop_ok;
    logic [MAIN_SIZE:0]   count_reg;
    logic [MAIN_SIZE:0]   count_next;
    logic                 data_valid_reg;
    logic [1:0]           ptr_en;
    logic [MAIN_SIZE-1:0] ptr_q [2];

    assign full    = (count_reg == DEPTH);
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign write = push_ok;
    assign read  = pop_ok;

    // Index 0 is the write pointer, index 1 the read pointer.
    assign ptr_en = {pop_ok, push_ok};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
        fifo_ptr_cnt #(
            .W (MAIN_SIZE)
        ) u_ptr (
            .clk   (clk),
            .reset (reset),
            .en    (ptr_en[gi]),
            .q     (ptr_q[gi])
        );
    end

    assign wr_ptr = ptr_q[0];
    assign rd_ptr = ptr_q[1];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + ONE;
            2'b01:   count_next = count_reg - ONE;
            default: count_next = count_reg;
        endcase
    end

    // data_valid lines up with the memory's registered data_out after an accepted pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg      <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            data_valid_reg <= pop_ok;
        end
    end

    assign count        = count_reg;
    assign data_valid   = data_valid_reg;
    assign almost_full  = (count_reg >= af_thr);
    assign almost_empty = (count_reg <= ae_thr);

`ifdef FIFO_ERR_EN
    logic error_reg;

    // Sticky until reset so a single rejected request is never missed by slow monitors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_reg <= 1'b0;
        end else if ((push & full) | (pop & empty)) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_6x8.sv
// Directed-vector bench for fifo_ctrl_6x8 with a behavioural memory6x8 model for data ordering.
module tb_fifo_ctrl_6x8;

    localparam bit ERR_EN =
`ifdef FIFO_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [6:0] af_thr;
    logic [6:0] ae_thr;
    logic       write;
    logic       read;
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [6:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       data_valid;
    logic       error;

    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] mem [64];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fifo_ctrl_6x8 dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .af_thr       (af_thr),
        .ae_thr       (ae_thr),
        .write        (write),
        .read         (read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_valid   (data_valid),
        .error        (error)
    );

    // Behavioural stand-in for memory6x8: registered write and registered read.
    always @(posedge clk) begin
        if (write) mem[wr_ptr] <= din;
        if (read)  dout <= mem[rd_ptr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %-16s act=%0h", name, act);
        end else begin
            $display("FAIL %-16s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        #1;
        step();
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic       push;
        logic       pop;
        logic [6:0] af;
        logic [6:0] ae;
        logic [6:0] cnt;
        logic       full;
        logic       empty;
        logic       afl;
        logic       aem;
        logic       wr;
        logic       rd;
        logic       dv;
        logic       err;
        logic [5:0] wp;
        logic [5:0] rp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [26:0] act_bits;
        logic [26:0] exp_bits;
        logic [7:0]  next_rd;
        int          n_out;

        // push pop af ae | cnt full empty afl aem wr rd dv err | wp rp  (state before the edge)
        vecs[0]  = '{1'b0, 1'b0, 7'd56, 7'd8, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
        vecs[1]  = '{1'b0, 1'b1, 7'd3,  7'd1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
        vecs[2]  = '{1'b1, 1'b0, 7'd3,  7'd1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0};
        vecs[3]  = '{1'b1, 1'b1, 7'd3,  7'd1, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 6'd0};
        vecs[4]  = '{1'b1, 1'b0, 7'd3,  7'd1, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 6'd1};
        vecs[5]  = '{1'b1, 1'b0, 7'd3,  7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 6'd1};
        vecs[6]  = '{1'b0, 1'b0, 7'd3,  7'd1, 7'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 6'd1};
        vecs[7]  = '{1'b0, 1'b0, 7'd4,  7'd1, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 6'd1};
        vecs[8]  = '{1'b0, 1'b1, 7'd4,  7'd3, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd4, 6'd1};
        vecs[9]  = '{1'b0, 1'b1, 7'd0,  7'd3, 7'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd4, 6'd2};
        vecs[10] = '{1'b0, 1'b1, 7'd0,  7'd0, 7'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd4, 6'd3};
        vecs[11] = '{1'b0, 1'b1, 7'd64, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd4, 6'd4};

        reset  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        af_thr = 7'd56;
        ae_thr = 7'd8;
        din    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Table: mixed push/pop, simultaneous ops, threshold edges, pop-on-empty.
        for (int i = 0; i < 12; i++) begin
            push   = vecs[i].push;
            pop    = vecs[i].pop;
            af_thr = vecs[i].af;
            ae_thr = vecs[i].ae;
            @(negedge clk);
            act_bits = {count, full, empty, almost_full, almost_empty, write, read,
                        data_valid, error, wr_ptr, rd_ptr};
            exp_bits = {vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].afl, vecs[i].aem,
                        vecs[i].wr, vecs[i].rd, vecs[i].dv, vecs[i].err & ERR_EN,
                        vecs[i].wp, vecs[i].rp};
            check($sformatf("vec%0d", i), 32'(act_bits), 32'(exp_bits));
            step();
        end

        // Fill all 64 entries, then one rejected push.
        af_thr = 7'd56;
        ae_thr = 7'd8;
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        for (int i = 0; i < 64; i++) begin
            push = 1'b1;
            din  = 8'(i);
            step();
        end
        @(negedge clk);
        check("fill_count", 32'(count), 32'd64);
        check("fill_full", 32'({full, almost_full, empty}), 32'b110);
        check("fill_wrptr", 32'(wr_ptr), 32'd0);
        check("ovf_write", 32'(write), 32'd0);
        step();
        push = 1'b0;
        @(negedge clk);
        check("ovf_count", 32'(count), 32'd64);
        check("ovf_err", 32'(error), 32'(ERR_EN));
        step();

        // Drain: data_valid trails each read by one cycle, data in push order.
        for (int i = 0; i < 64; i++) begin
            pop = 1'b1;
            @(negedge clk);
            check($sformatf("drain_rd%0d", i), 32'(read), 32'd1);
            if (i > 0) check($sformatf("drain_d%0d", i - 1), 32'({data_valid, dout}), 32'({1'b1, 8'(i - 1)}));
            step();
        end
        pop = 1'b0;
        @(negedge clk);
        check("drain_d63", 32'({data_valid, dout}), 32'({1'b1, 8'd63}));
        check("drain_empty", 32'({empty, count}), 32'({1'b1, 7'd0}));
        check("drain_rdptr", 32'(rd_ptr), 32'd0);
        step();

        // Pop on empty.
        pop = 1'b1;
        @(negedge clk);
        check("udf_read", 32'({read, data_valid}), 32'd0);
        step();
        pop = 1'b0;
        @(negedge clk);
        check("udf_state", 32'({data_valid, count}), 32'd0);
        check("udf_err", 32'(error), 32'(ERR_EN));
        step();

        // Hold at 10 entries with simultaneous push/pop for 100 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push = 1'b1;
            din  = 8'(100 + i);
            step();
        end
        next_rd = 8'd100;
        n_out   = 0;
        for (int k = 0; k < 101; k++) begin
            push = (k < 100);
            pop  = (k < 100);
            din  = 8'(110 + k);
            @(negedge clk);
            if (data_valid) begin
                check("stream_data", 32'(dout), 32'(next_rd));
                next_rd = next_rd + 8'd1;
                n_out++;
            end
            step();
        end
        @(negedge clk);
        check("stream_outs", 32'(n_out), 32'd100);
        check("stream_count", 32'(count), 32'd10);
        check("stream_ptrs", 32'({wr_ptr, rd_ptr}), 32'({6'd46, 6'd36}));
        step();

        // Fill to 30, then asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            push = 1'b1;
            din  = 8'(i);
            step();
        end
        push = 1'b0;
        pop  = 1'b1;
        @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd30);
        reset = 1'b0;
        #1;
        check("arst_state", 32'({count, wr_ptr, rd_ptr, error}), 32'd0);
        check("arst_flags", 32'({empty, full, almost_empty, write, read}), 32'b10100);
        step();
        reset = 1'b1;
        pop   = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
